// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
//   Shared definitions for the program loader: FSM state type, length-header
//   size and the default bytes-per-word for a 32-bit instruction word.
// ---------------------------------------------------------------------------
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_WRITE,
      ST_DONE,
      ST_ERR
   } loader_state_t;

   localparam int unsigned LEN_BYTES      = 2;
   localparam int unsigned DEFAULT_WIDTH  = 32;
   localparam int unsigned BYTES_PER_WORD = DEFAULT_WIDTH / 8;

endpackage

// File: rtl/word_packer.sv
// ---------------------------------------------------------------------------
// word_packer
//   Little-endian byte-to-word assembler. Bytes shift in from the top so the
//   first byte of a word ends up in bits [7:0].
// Ports
//   clk          in   clock
//   reset        in   asynchronous active-low reset
//   i_clear      in   discard any partial word and restart at byte 0
//   i_valid      in   a byte is accepted this cycle
//   i_data       in   the accepted byte
//   o_word_valid out  this cycle's byte completes a word
//   o_word       out  the completed word (valid with o_word_valid)
// ---------------------------------------------------------------------------
module word_packer
   import loader_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_valid,
   input  logic [7:0]       i_data,
   output logic             o_word_valid,
   output logic [WIDTH-1:0] o_word
);

   localparam int unsigned BPW = WIDTH / 8;
   localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] w_next;
   logic             w_last;

   // Completed word is presented combinationally so the final byte does not
   // cost an extra cycle before the write.
   assign w_next       = (r_shift >> 8) | (WIDTH'(i_data) << (WIDTH - 8));
   assign w_last       = i_valid && (r_cnt == CW'(BPW - 1));
   assign o_word_valid = w_last;
   assign o_word       = w_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_clear) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_valid) begin
         r_shift <= w_next;
         r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Writer side of the instruction memory. Receives a framed byte stream
//   (16-bit LE word count N, then N little-endian words), writes the words to
//   program memory from address 0 and holds the CPU in reset meanwhile.
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   one-cycle pulse starting a session (IDLE/DONE/ERR only)
//   s_valid      in   byte stream valid
//   s_data       in   byte stream data
//   s_ready      out  byte accepted this cycle when s_valid is high
//   mem_wr_en    out  one-cycle write strobe per word
//   mem_addr     out  word address (held between writes)
//   mem_wr_data  out  word data (held between writes)
//   cpu_hold     out  keep CPU core in reset while loading
//   done         out  last session completed
//   error        out  last session rejected (N > DEPTH)
// ---------------------------------------------------------------------------
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DEPTH      = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   output logic                  s_ready,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]      mem_wr_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned LEN_BITS = LEN_BYTES * 8;

   loader_state_t         r_state;
   loader_state_t         w_next_state;
   logic [LEN_BITS-1:0]   r_len;
   logic [ADDR_WIDTH:0]   r_word_idx;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [WIDTH-1:0]      r_mem_wr_data;

   logic                  w_accept;
   logic                  w_start_ok;
   logic [LEN_BITS-1:0]   w_len_full;
   logic                  w_last_word;
   logic                  w_word_valid;
   logic [WIDTH-1:0]      w_word;

   assign w_accept    = s_valid && s_ready;
   assign w_start_ok  = start && (r_state inside {ST_IDLE, ST_DONE, ST_ERR});
   assign w_len_full  = {s_data, r_len[7:0]};
   assign w_last_word = (32'(r_word_idx) + 32'd1) == 32'(r_len);

   word_packer #(
      .WIDTH (WIDTH)
   ) u_packer (
      .clk          (clk),
      .reset        (reset),
      .i_clear      (w_start_ok),
      .i_valid      (w_accept && (r_state == ST_DATA)),
      .i_data       (s_data),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      s_ready      = 1'b0;
      cpu_hold     = 1'b0;
      done         = 1'b0;
      error        = 1'b0;
      mem_wr_en    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next_state = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            s_ready  = 1'b1;
            cpu_hold = 1'b1;
            if (w_accept) w_next_state = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            s_ready  = 1'b1;
            cpu_hold = 1'b1;
            if (w_accept) begin
               if (w_len_full == '0)                w_next_state = ST_DONE;
               else if (32'(w_len_full) > DEPTH)    w_next_state = ST_ERR;
               else                                 w_next_state = ST_DATA;
            end
         end
         ST_DATA: begin
            s_ready  = 1'b1;
            cpu_hold = 1'b1;
            if (w_word_valid) w_next_state = ST_WRITE;
         end
         ST_WRITE: begin
            cpu_hold     = 1'b1;
            mem_wr_en    = 1'b1;
            w_next_state = w_last_word ? ST_DONE : ST_DATA;
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) w_next_state = ST_LEN_LO;
         end
         ST_ERR: begin
            error = 1'b1;
            if (start) w_next_state = ST_LEN_LO;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Address and data are captured with the final byte, so they are already
   // stable during the WRITE cycle and simply hold afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_len         <= '0;
         r_word_idx    <= '0;
         r_mem_addr    <= '0;
         r_mem_wr_data <= '0;
      end else begin
         if (w_start_ok) begin
            r_len      <= '0;
            r_word_idx <= '0;
         end else begin
            if (w_accept && (r_state == ST_LEN_LO)) r_len[7:0] <= s_data;
            if (w_accept && (r_state == ST_LEN_HI)) r_len      <= w_len_full;
            if ((r_state == ST_WRITE) && !w_last_word) r_word_idx <= r_word_idx + 1'b1;
         end
         if (w_word_valid) begin
            r_mem_addr    <= r_word_idx[ADDR_WIDTH-1:0];
            r_mem_wr_data <= w_word;
         end
      end
   end

   assign mem_addr    = r_mem_addr;
   assign mem_wr_data = r_mem_wr_data;

endmodule
